tt_um_emern_scene_loader: RTL and testbench

//  Configuration controller for tt_um_emern_pixel_core.
//  - Accepts a byte-stream of scene commands over a valid/ready handshake.
//  - Writes the commands into a shadow bank holding polygon colours, vertices, enable mask and background colour.
//  - Copies the shadow bank into the active bank on frame_start, so the pixel core never sees a half-updated scene mid-frame.
//  - The active bank drives the pixel core's packed inputs directly.

---
 rtl/tt_um_emern_scene_loader_pkg.sv | 64 ++++++
 rtl/tt_um_emern_scene_bank.sv | 112 +++++++++++
 rtl/tt_um_emern_scene_loader.sv | 210 +++++++++++++++++++++
 tb/tb_tt_um_emern_scene_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_emern_scene_loader_pkg.sv
// Shared scene-loader constants, opcode encodings, field codes and the
// byte-merge helpers used when building coordinates from 16-bit
// little-endian byte pairs.
package tt_um_emern_scene_loader_pkg;

    localparam int N_POLY = 6;   // polygon slots, slot 0 = closest
    localparam int WPX    = 10;  // x-coordinate width
    localparam int WPY    = 9;   // y-coordinate width
    localparam int WCOLOR = 6;   // rrggbb

    // Header opcodes (header byte bits [7:5])
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WR_POLY = 3'd1;
    localparam logic [2:0] OP_SET_BG  = 3'd2;
    localparam logic [2:0] OP_SET_EN  = 3'd3;
    localparam logic [2:0] OP_COMMIT  = 3'd4;

    // Payload lengths in bytes
    localparam logic [3:0] LEN_WR_POLY = 4'd13;
    localparam logic [3:0] LEN_SET_BG  = 4'd1;
    localparam logic [3:0] LEN_SET_EN  = 4'd1;

    // Shadow-bank field codes. The vertex codes follow WR_POLY payload
    // order, so payload byte k (k >= 1) maps to field (k+1)/2.
    typedef enum logic [3:0] {
        FLD_COLOR = 4'd0,
        FLD_V0X   = 4'd1,
        FLD_V0Y   = 4'd2,
        FLD_V1X   = 4'd3,
        FLD_V1Y   = 4'd4,
        FLD_V2X   = 4'd5,
        FLD_V2Y   = 4'd6,
        FLD_BG    = 4'd7,
        FLD_EN    = 4'd8
    } field_e;

    // Merge one byte of a little-endian pair into an x coordinate;
    // high-byte bits above WPX are dropped.
    function automatic logic [WPX-1:0] merge_x(input logic [WPX-1:0] old_v,
                                               input logic [7:0]     b,
                                               input logic           hi);
        logic [WPX-1:0] res;
        if (hi) begin
            res = {b[WPX-9:0], old_v[7:0]};
        end else begin
            res = {old_v[WPX-1:8], b};
        end
        return res;
    endfunction

    // Same as merge_x for a y coordinate.
    function automatic logic [WPY-1:0] merge_y(input logic [WPY-1:0] old_v,
                                               input logic [7:0]     b,
                                               input logic           hi);
        logic [WPY-1:0] res;
        if (hi) begin
            res = {b[WPY-9:0], old_v[7:0]};
        end else begin
            res = {old_v[WPY-1:8], b};
        end
        return res;
    endfunction

endpackage

// File: rtl/tt_um_emern_scene_bank.sv
// Shadow and active scene registers for all polygon slots.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_wr_en         write strobe for one shadow field byte
//   i_wr_slot       polygon slot addressed (ignored for BG / EN)
//   i_wr_field      which shadow field is written
//   i_wr_hi         0 = low byte of a coordinate pair, 1 = high byte
//   i_wr_data       byte written
//   i_swap          copy the whole shadow bank into the active bank
//   o_*             active bank, packed with slot k at [W*(k+1)-1 : W*k]
module tt_um_emern_scene_bank
    import tt_um_emern_scene_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [2:0]                 i_wr_slot,
    input  field_e                     i_wr_field,
    input  logic                       i_wr_hi,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_swap,
    output logic [N_POLY-1:0]          o_cmp_en,
    output logic [WCOLOR-1:0]          o_background_color,
    output logic [WCOLOR*N_POLY-1:0]   o_poly_color,
    output logic [WPX*N_POLY-1:0]      o_v0_x,
    output logic [WPX*N_POLY-1:0]      o_v1_x,
    output logic [WPX*N_POLY-1:0]      o_v2_x,
    output logic [WPY*N_POLY-1:0]      o_v0_y,
    output logic [WPY*N_POLY-1:0]      o_v1_y,
    output logic [WPY*N_POLY-1:0]      o_v2_y
);

    logic [WCOLOR-1:0] r_sh_col  [N_POLY];
    logic [WPX-1:0]    r_sh_vx   [3][N_POLY];
    logic [WPY-1:0]    r_sh_vy   [3][N_POLY];
    logic [WCOLOR-1:0] r_sh_bg;
    logic [N_POLY-1:0] r_sh_en;

    logic [WCOLOR-1:0] r_act_col [N_POLY];
    logic [WPX-1:0]    r_act_vx  [3][N_POLY];
    logic [WPY-1:0]    r_act_vy  [3][N_POLY];
    logic [WCOLOR-1:0] r_act_bg;
    logic [N_POLY-1:0] r_act_en;

    // Shadow bank: byte-granular field writes from the loader.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_POLY; k++) begin
                r_sh_col[k] <= '0;
                for (int v = 0; v < 3; v++) begin
                    r_sh_vx[v][k] <= '0;
                    r_sh_vy[v][k] <= '0;
                end
            end
            r_sh_bg <= '0;
            r_sh_en <= '0;
        end else if (i_wr_en) begin
            case (i_wr_field)
                FLD_COLOR: r_sh_col[i_wr_slot]   <= i_wr_data[WCOLOR-1:0];
                FLD_V0X:   r_sh_vx[0][i_wr_slot] <= merge_x(r_sh_vx[0][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_V0Y:   r_sh_vy[0][i_wr_slot] <= merge_y(r_sh_vy[0][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_V1X:   r_sh_vx[1][i_wr_slot] <= merge_x(r_sh_vx[1][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_V1Y:   r_sh_vy[1][i_wr_slot] <= merge_y(r_sh_vy[1][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_V2X:   r_sh_vx[2][i_wr_slot] <= merge_x(r_sh_vx[2][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_V2Y:   r_sh_vy[2][i_wr_slot] <= merge_y(r_sh_vy[2][i_wr_slot], i_wr_data, i_wr_hi);
                FLD_BG:    r_sh_bg               <= i_wr_data[WCOLOR-1:0];
                FLD_EN:    r_sh_en               <= i_wr_data[N_POLY-1:0];
                default:   r_sh_en               <= r_sh_en;
            endcase
        end else begin
            r_sh_en <= r_sh_en;
        end
    end

    // Active bank: updated only by a whole-bank swap, so the pixel core
    // never observes a partially written scene.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_POLY; k++) begin
                r_act_col[k] <= '0;
                for (int v = 0; v < 3; v++) begin
                    r_act_vx[v][k] <= '0;
                    r_act_vy[v][k] <= '0;
                end
            end
            r_act_bg <= '0;
            r_act_en <= '0;
        end else if (i_swap) begin
            r_act_col <= r_sh_col;
            r_act_vx  <= r_sh_vx;
            r_act_vy  <= r_sh_vy;
            r_act_bg  <= r_sh_bg;
            r_act_en  <= r_sh_en;
        end else begin
            r_act_en  <= r_act_en;
        end
    end

    assign o_cmp_en           = r_act_en;
    assign o_background_color = r_act_bg;

    for (genvar k = 0; k < N_POLY; k++) begin : g_pack
        assign o_poly_color[WCOLOR*k +: WCOLOR] = r_act_col[k];
        assign o_v0_x[WPX*k +: WPX]             = r_act_vx[0][k];
        assign o_v1_x[WPX*k +: WPX]             = r_act_vx[1][k];
        assign o_v2_x[WPX*k +: WPX]             = r_act_vx[2][k];
        assign o_v0_y[WPY*k +: WPY]             = r_act_vy[0][k];
        assign o_v1_y[WPY*k +: WPY]             = r_act_vy[1][k];
        assign o_v2_y[WPY*k +: WPY]             = r_act_vy[2][k];
    end

endmodule

// File: rtl/tt_um_emern_scene_loader.sv
// Scene-command loader for the pixel core: decodes a byte stream of
// commands, writes the shadow bank and swaps it into the active bank on
// the first frame_start after a COMMIT.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/valid/ready byte stream, transfer = in_valid & in_ready
//   frame_start        1-cycle pulse at start of vertical blank
//   cmp_en .. v2_y     active scene, packed per slot
//   commit_pending     COMMIT accepted, swap not yet done
//   cmd_err            sticky bad opcode / bad slot flag
module tt_um_emern_scene_loader
    import tt_um_emern_scene_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       frame_start,
    output logic [N_POLY-1:0]          cmp_en,
    output logic [WCOLOR-1:0]          background_color,
    output logic [WCOLOR*N_POLY-1:0]   poly_color,
    output logic [WPX*N_POLY-1:0]      v0_x,
    output logic [WPX*N_POLY-1:0]      v1_x,
    output logic [WPX*N_POLY-1:0]      v2_x,
    output logic [WPY*N_POLY-1:0]      v0_y,
    output logic [WPY*N_POLY-1:0]      v1_y,
    output logic [WPY*N_POLY-1:0]      v2_y,
    output logic                       commit_pending,
    output logic                       cmd_err
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_PAYLOAD     = 2'd1;
    localparam logic [1:0] S_COMMIT_WAIT = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_op;
    logic [2:0] r_slot;
    logic       r_slot_bad;
    logic       r_in_ready;
    logic       r_commit_pending;
    logic       r_cmd_err;

    logic       w_xfer;
    logic [2:0] w_hdr_op;
    logic [2:0] w_hdr_slot;
    logic [3:0] w_idx;
    logic [3:0] w_idx_p1;
    logic       w_wr_en;
    field_e     w_wr_field;
    logic       w_wr_hi;
    logic       w_swap;

    assign w_xfer     = in_valid & r_in_ready;
    assign w_hdr_op   = in_data[7:5];
    assign w_hdr_slot = in_data[2:0];
    // Index of the current WR_POLY payload byte, 0..12.
    assign w_idx      = LEN_WR_POLY - r_cnt;
    assign w_idx_p1   = w_idx + 4'd1;
    assign w_swap     = (r_state == S_COMMIT_WAIT) & frame_start;

    // Payload byte -> shadow field address decode.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_field = FLD_COLOR;
        w_wr_hi    = 1'b0;
        if ((r_state == S_PAYLOAD) && w_xfer) begin
            case (r_op)
                OP_WR_POLY: begin
                    // Out-of-range slots still consume their payload but never write.
                    w_wr_en = ~r_slot_bad;
                    if (w_idx == 4'd0) begin
                        w_wr_field = FLD_COLOR;
                        w_wr_hi    = 1'b0;
                    end else begin
                        // Odd index = low byte of a pair, even index = high byte.
                        w_wr_field = field_e'({1'b0, w_idx_p1[3:1]});
                        w_wr_hi    = ~w_idx[0];
                    end
                end
                OP_SET_BG: begin
                    w_wr_en    = 1'b1;
                    w_wr_field = FLD_BG;
                end
                OP_SET_EN: begin
                    w_wr_en    = 1'b1;
                    w_wr_field = FLD_EN;
                end
                default: begin
                    w_wr_en    = 1'b0;
                end
            endcase
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Command FSM, byte counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 4'd0;
            r_op             <= OP_NOP;
            r_slot           <= 3'd0;
            r_slot_bad       <= 1'b0;
            r_in_ready       <= 1'b1;
            r_commit_pending <= 1'b0;
            r_cmd_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_op   <= w_hdr_op;
                        r_slot <= w_hdr_slot;
                        case (w_hdr_op)
                            OP_WR_POLY: begin
                                r_state    <= S_PAYLOAD;
                                r_cnt      <= LEN_WR_POLY;
                                r_slot_bad <= (w_hdr_slot >= 3'(N_POLY));
                                if (w_hdr_slot >= 3'(N_POLY)) begin
                                    r_cmd_err <= 1'b1;
                                end else begin
                                    r_cmd_err <= r_cmd_err;
                                end
                            end
                            OP_SET_BG: begin
                                r_state    <= S_PAYLOAD;
                                r_cnt      <= LEN_SET_BG;
                                r_slot_bad <= 1'b0;
                            end
                            OP_SET_EN: begin
                                r_state    <= S_PAYLOAD;
                                r_cnt      <= LEN_SET_EN;
                                r_slot_bad <= 1'b0;
                            end
                            OP_COMMIT: begin
                                r_state          <= S_COMMIT_WAIT;
                                r_in_ready       <= 1'b0;
                                r_commit_pending <= 1'b1;
                            end
                            OP_NOP: begin
                                r_state <= S_IDLE;
                            end
                            default: begin
                                // Undefined opcodes behave as NOP but are flagged.
                                r_state   <= S_IDLE;
                                r_cmd_err <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end else begin
                        r_state <= S_PAYLOAD;
                    end
                end
                S_COMMIT_WAIT: begin
                    if (frame_start) begin
                        r_state          <= S_IDLE;
                        r_in_ready       <= 1'b1;
                        r_commit_pending <= 1'b0;
                    end else begin
                        r_state <= S_COMMIT_WAIT;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_in_ready       <= 1'b1;
                    r_commit_pending <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign commit_pending = r_commit_pending;
    assign cmd_err        = r_cmd_err;

    tt_um_emern_scene_bank u_bank (
        .clk                (clk),
        .rst                (rst),
        .i_wr_en            (w_wr_en),
        .i_wr_slot          (r_slot),
        .i_wr_field         (w_wr_field),
        .i_wr_hi            (w_wr_hi),
        .i_wr_data          (in_data),
        .i_swap             (w_swap),
        .o_cmp_en           (cmp_en),
        .o_background_color (background_color),
        .o_poly_color       (poly_color),
        .o_v0_x             (v0_x),
        .o_v1_x             (v1_x),
        .o_v2_x             (v2_x),
        .o_v0_y             (v0_y),
        .o_v1_y             (v1_y),
        .o_v2_y             (v2_y)
    );

endmodule

// File: tb/tb_tt_um_emern_scene_loader.sv
module tb_tt_um_emern_scene_loader;

    localparam int NP = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        frame_start;
    logic [5:0]  cmp_en;
    logic [5:0]  background_color;
    logic [35:0] poly_color;
    logic [59:0] v0_x, v1_x, v2_x;
    logic [53:0] v0_y, v1_y, v2_y;
    logic        commit_pending;
    logic        cmd_err;

    tt_um_emern_scene_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .frame_start(frame_start), .cmp_en(cmp_en),
        .background_color(background_color), .poly_color(poly_color),
        .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x),
        .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
        .commit_pending(commit_pending), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  en;
        logic [5:0]  bg;
        logic [35:0] col;
        logic [59:0] v0x;
        logic [59:0] v1x;
        logic [59:0] v2x;
        logic [53:0] v0y;
        logic [53:0] v1y;
        logic [53:0] v2y;
    } scene_t;

    // Reference model of the shadow bank (plain integers, truncated by modulo)
    int     m_col [NP];
    int     m_vx  [3][NP];
    int     m_vy  [3][NP];
    int     m_bg;
    int     m_en;
    bit     m_err;

    scene_t exp_q[$];
    scene_t exp_act;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic scene_t model_snapshot();
        scene_t s;
        s     = '0;
        s.en  = 6'(m_en);
        s.bg  = 6'(m_bg);
        for (int k = 0; k < NP; k++) begin
            s.col[6*k +: 6]  = 6'(m_col[k]);
            s.v0x[10*k +: 10] = 10'(m_vx[0][k]);
            s.v1x[10*k +: 10] = 10'(m_vx[1][k]);
            s.v2x[10*k +: 10] = 10'(m_vx[2][k]);
            s.v0y[9*k +: 9]   = 9'(m_vy[0][k]);
            s.v1y[9*k +: 9]   = 9'(m_vy[1][k]);
            s.v2y[9*k +: 9]   = 9'(m_vy[2][k]);
        end
        return s;
    endfunction

    // Monitor: a falling commit_pending marks a swap; pop the scene expected
    // for that commit, then hold every active output against it each cycle.
    initial begin : monitor
        bit prev_pending;
        prev_pending = 1'b0;
        exp_act      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pending = 1'b0;
            end else begin
                if (prev_pending && !commit_pending) begin
                    chk("swap_has_commit", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) exp_act = exp_q.pop_front();
                end
                chk("cmp_en",     64'(cmp_en),           64'(exp_act.en));
                chk("background", 64'(background_color), 64'(exp_act.bg));
                chk("poly_color", 64'(poly_color),       64'(exp_act.col));
                chk("v0_x",       64'(v0_x),             64'(exp_act.v0x));
                chk("v1_x",       64'(v1_x),             64'(exp_act.v1x));
                chk("v2_x",       64'(v2_x),             64'(exp_act.v2x));
                chk("v0_y",       64'(v0_y),             64'(exp_act.v0y));
                chk("v1_y",       64'(v1_y),             64'(exp_act.v1y));
                chk("v2_y",       64'(v2_y),             64'(exp_act.v2y));
                prev_pending = commit_pending;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // One byte transfer after `gap` idle cycles; returns just after the edge.
    task automatic send_byte(input logic [7:0] b, input bit fs, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = b;
        frame_start = fs;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: in_ready low for %0d cycles", waited);
            in_valid    = 1'b0;
            frame_start = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid    = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    function automatic logic [7:0] hdr(input int op, input int slot);
        return {3'(op), 2'($urandom_range(3, 0)), 3'(slot)};
    endfunction

    task automatic do_wr_poly(input int slot, input int color, input int c0, input int c1,
                              input int c2, input int c3, input int c4, input int c5,
                              input int gap);
        int c[6];
        c = '{c0, c1, c2, c3, c4, c5};
        send_byte(hdr(1, slot), 1'b0, gap);
        send_byte(8'(color), 1'b0, gap);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(c[i]), 1'b0, gap);
            send_byte(8'(c[i] >> 8), 1'b0, gap);
        end
        if (slot < NP) begin
            m_col[slot]   = color % 64;
            m_vx[0][slot] = c[0] % 1024;
            m_vy[0][slot] = c[1] % 512;
            m_vx[1][slot] = c[2] % 1024;
            m_vy[1][slot] = c[3] % 512;
            m_vx[2][slot] = c[4] % 1024;
            m_vy[2][slot] = c[5] % 512;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic do_set_bg(input int b, input int gap);
        send_byte(hdr(2, $urandom_range(7, 0)), 1'b0, gap);
        send_byte(8'(b), 1'b0, gap);
        m_bg = b % 64;
    endtask

    task automatic do_set_en(input int b, input int gap);
        send_byte(hdr(3, $urandom_range(7, 0)), 1'b0, gap);
        send_byte(8'(b), 1'b0, gap);
        m_en = b % 64;
    endtask

    // COMMIT header; the expected scene is queued, then the wait state is probed.
    task automatic do_commit(input bit fs, input int probe);
        send_byte(hdr(4, $urandom_range(7, 0)), fs, 0);
        exp_q.push_back(model_snapshot());
        for (int i = 0; i < probe; i++) begin
            @(negedge clk);
            chk("wait_in_ready", 64'(in_ready), 64'd0);
            chk("wait_pending",  64'(commit_pending), 64'd1);
        end
    endtask

    task automatic pulse_frame(input bit expect_swap);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (expect_swap) begin
            chk("swap_latency_pending", 64'(commit_pending), 64'd0);
            chk("swap_in_ready",        64'(in_ready), 64'd1);
        end
    endtask

    task automatic check_err();
        @(negedge clk);
        chk("cmd_err", 64'(cmd_err), 64'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) begin
            m_col[k] = 0;
            for (int v = 0; v < 3; v++) begin
                m_vx[v][k] = 0;
                m_vy[v][k] = 0;
            end
        end
        m_bg    = 0;
        m_en    = 0;
        m_err   = 1'b0;
        exp_q.delete();
        exp_act = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_pending",  64'(commit_pending), 64'd0);
        chk("reset_cmd_err",  64'(cmd_err), 64'd0);
    endtask

    initial begin : stimulus
        int sel;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);

        // 1: reset state
        do_reset();
        repeat (3) @(negedge clk);

        // 2: WR_POLY slot 2, SET_EN, COMMIT, frame_start
        do_wr_poly(2, 'h30, 100, 50, 200, 50, 150, 120, 0);
        do_set_en('h04, 0);
        do_commit(1'b0, 4);
        pulse_frame(1'b1);
        chk("t2_color_slot2", 64'(poly_color[17:12]), 64'h30);
        chk("t2_v1x_slot2",   64'(v1_x[29:20]),       64'd200);
        chk("t2_cmp_en",      64'(cmp_en),            64'h04);

        // 3: COMMIT in the same cycle as frame_start does not swap
        do_set_bg('h2A, 0);
        do_commit(1'b1, 3);
        chk("t3_bg_held", 64'(background_color), 64'h00);
        pulse_frame(1'b1);
        chk("t3_bg_swapped", 64'(background_color), 64'h2A);

        // 4: WR_POLY to slot 7 is consumed, flagged and harmless
        send_byte(8'h27, 1'b0, 0);
        for (int i = 0; i < 13; i++) send_byte(8'($urandom_range(255, 0)), 1'b0, 0);
        m_err = 1'b1;
        check_err();
        do_set_en('h3F, 0);
        do_commit(1'b0, 1);
        pulse_frame(1'b1);
        chk("t4_cmp_en", 64'(cmp_en), 64'h3F);

        // 5: reset mid-packet and mid-commit
        send_byte(hdr(1, 1), 1'b0, 0);
        for (int i = 0; i < 6; i++) send_byte(8'hA5, 1'b0, 0);
        do_reset();
        do_set_bg('h15, 0);
        do_commit(1'b0, 1);
        pulse_frame(1'b1);
        chk("t5_bg", 64'(background_color), 64'h15);
        do_set_en('h21, 0);
        do_commit(1'b0, 1);
        do_reset();
        pulse_frame(1'b0);

        // 6: gapped vs back-to-back transfer, 0xFFFF truncation
        do_wr_poly(0, 'hFF, 'hFFFF, 'hFFFF, 'h1234, 'hFFFF, 'hFFFF, 'hABCD, 1);
        do_wr_poly(3, 'hFF, 'hFFFF, 'hFFFF, 'h1234, 'hFFFF, 'hFFFF, 'hABCD, 0);
        do_commit(1'b0, 1);
        pulse_frame(1'b1);
        chk("t6_v0x_trunc", 64'(v0_x[9:0]), 64'h3FF);
        chk("t6_v0y_trunc", 64'(v0_y[8:0]), 64'h1FF);
        chk("t6_gap_eq_v1x", 64'(v1_x[9:0]), 64'(v1_x[39:30]));
        chk("t6_gap_eq_v2y", 64'(v2_y[8:0]), 64'(v2_y[35:27]));

        // Randomised command mix
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(99, 0);
            if (sel < 35) begin
                do_wr_poly($urandom_range(7, 0), $urandom_range(255, 0),
                           $urandom_range(65535, 0), $urandom_range(65535, 0),
                           $urandom_range(65535, 0), $urandom_range(65535, 0),
                           $urandom_range(65535, 0), $urandom_range(65535, 0),
                           $urandom_range(2, 0));
            end else if (sel < 45) begin
                do_set_bg($urandom_range(255, 0), $urandom_range(2, 0));
            end else if (sel < 55) begin
                do_set_en($urandom_range(255, 0), $urandom_range(2, 0));
            end else if (sel < 62) begin
                send_byte(hdr(0, $urandom_range(7, 0)), 1'b0, 0);
            end else if (sel < 66) begin
                send_byte(hdr($urandom_range(7, 5), $urandom_range(7, 0)), 1'b0, 0);
                m_err = 1'b1;
            end else if (sel < 74) begin
                pulse_frame(1'b0);
            end else begin
                do_commit(1'b0, $urandom_range(3, 0));
                repeat ($urandom_range(3, 0)) @(negedge clk);
                pulse_frame(1'b1);
            end
            check_err();
        end
        do_commit(1'b0, 1);
        pulse_frame(1'b1);
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
